// File: rtl/queue_reader_if.sv
// Handshake bundle for queue_reader: upstream pop port and downstream valid/ready port.
// master is the reader side, slave is the queue/consumer environment side.
interface queue_reader_if #(
  parameter int DATA = 42
);
  logic            q_empty;
  logic [DATA-1:0] q_rdata;
  logic            q_ren;
  logic [DATA-1:0] out_data;
  logic            out_valid;
  logic            out_ready;

  modport master (
    input  q_empty, q_rdata, out_ready,
    output q_ren, out_data, out_valid
  );

  modport slave (
    output q_empty, q_rdata, out_ready,
    input  q_ren, out_data, out_valid
  );
endinterface

// File: rtl/queue_reader.sv
// Pops words from an upstream queue into a 2-entry head/skid buffer and streams them out.
// Optional build macro QUEUE_READER_CNT_EN adds a 16-bit delivered-word counter (xfer_count).
//
// state  | meaning
// IDLE   | no pops; buffered words still drain downstream
// STREAM | pop whenever the buffer has (or is making) room
// FLUSH  | pop and discard until the queue is empty; buffer held empty
module queue_reader #(
  parameter int ADDR = 5,
  parameter int DATA = 42
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  queue_reader_if.master    bus,
  output logic              busy
`ifdef QUEUE_READER_CNT_EN
  ,
  output logic [15:0]       xfer_count
`endif
);

  if (ADDR < 1) begin : g_addr_chk
    $error("queue_reader: ADDR must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t          state;
  logic [1:0]      occ;
  logic [DATA-1:0] head;
  logic [DATA-1:0] skid;
  logic            xfer;
  logic            pop;

  assign xfer          = bus.out_valid & bus.out_ready;
  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_data  = head;
  assign bus.q_ren     = pop;
  assign busy          = (state != IDLE) || (occ != 2'd0);

  // A full buffer may still accept a pop when the head leaves in the same cycle.
  always_comb begin
    pop = 1'b0;
    case (state)
      STREAM:  pop = !bus.q_empty && ((occ != 2'd2) || xfer);
      FLUSH:   pop = !bus.q_empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      occ   <= 2'd0;
      head  <= '0;
      skid  <= '0;
    end else begin
      if (flush) begin
        state <= FLUSH;
      end else begin
        case (state)
          IDLE:    if (en) state <= STREAM;
          STREAM:  if (!en) state <= IDLE;
          FLUSH:   if (bus.q_empty) state <= IDLE;
          default: state <= IDLE;
        endcase
      end

      // Anything popped while flushing (including the cycle flush is raised) is dropped.
      if (flush || (state == FLUSH)) begin
        occ <= 2'd0;
      end else begin
        case ({pop, xfer})
          2'b10: begin
            if (occ == 2'd0) begin
              head <= bus.q_rdata;
              occ  <= 2'd1;
            end else begin
              skid <= bus.q_rdata;
              occ  <= 2'd2;
            end
          end
          2'b01: begin
            head <= skid;
            occ  <= occ - 2'd1;
          end
          2'b11: begin
            if (occ == 2'd2) begin
              head <= skid;
              skid <= bus.q_rdata;
            end else begin
              head <= bus.q_rdata;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef QUEUE_READER_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_count <= 16'd0;
    end else if (xfer) begin
      xfer_count <= xfer_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_queue_reader.sv
// Self-checking bench for queue_reader: upstream queue model, scoreboard of expected words,
// and a monitor that compares every downstream transfer against the scoreboard.
module tb_queue_reader;
  localparam int DATA = 42;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic flush = 1'b0;
  logic busy;
`ifdef QUEUE_READER_CNT_EN
  logic [15:0] xfer_count;
`endif

  queue_reader_if #(.DATA(DATA)) bus();

  queue_reader #(.ADDR(5), .DATA(DATA)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .flush(flush),
    .bus(bus),
    .busy(busy)
`ifdef QUEUE_READER_CNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  always #5 clk = ~clk;

  // Upstream queue model: words live in mem[rd_ptr .. wr_ptr-1].
  logic [DATA-1:0] mem [int];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int pop_cnt = 0;

  assign bus.q_empty = (rd_ptr == wr_ptr);
  always_comb begin
    bus.q_rdata = '0;
    if (rd_ptr < wr_ptr) bus.q_rdata = mem[rd_ptr];
  end

  always @(posedge clk) begin
    if (bus.q_ren) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  logic [DATA-1:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [DATA-1:0] w, input bit deliver);
    mem[wr_ptr] = w;
    wr_ptr++;
    if (deliver) exp_q.push_back(w);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: a transfer completes on the next rising edge whenever valid and ready are high.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      logic [DATA-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_xfer: got %0h expected no transfer", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          errors++;
          $display("FAIL xfer_data: got %0h expected %0h", bus.out_data, e);
        end
      end
    end
  end

  initial begin
    int p;
    bus.out_ready = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_q_ren", 64'(bus.q_ren), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    rst = 1'b0;
    tick(1);

    // three words streamed back to back
    load(42'h0AA, 1'b1);
    load(42'h0BB, 1'b1);
    load(42'h0CC, 1'b1);
    bus.out_ready = 1'b1;
    en = 1'b1;
    p = pop_cnt;
    tick(1);
    check("t1_q_ren", 64'(bus.q_ren), 64'd1);
    tick(4);
    check("t1_pops", 64'(pop_cnt - p), 64'd3);
    check("t1_out_valid", 64'(bus.out_valid), 64'd0);
    check("t1_sb_empty", 64'(exp_q.size()), 64'd0);

    // backpressure: buffer fills with two words, head held
    bus.out_ready = 1'b0;
    load(42'h3_0000_0001, 1'b1);
    load(42'h3_0000_0002, 1'b1);
    load(42'h3_0000_0003, 1'b1);
    load(42'h3_0000_0004, 1'b1);
    load(42'h3_0000_0005, 1'b1);
    p = pop_cnt;
    tick(5);
    check("t2_pops_held", 64'(pop_cnt - p), 64'd2);
    check("t2_q_ren", 64'(bus.q_ren), 64'd0);
    check("t2_out_valid", 64'(bus.out_valid), 64'd1);
    check("t2_out_data", 64'(bus.out_data), 64'h3_0000_0001);
    bus.out_ready = 1'b1;
    tick(6);
    check("t2_pops_total", 64'(pop_cnt - p), 64'd5);
    check("t2_out_valid_end", 64'(bus.out_valid), 64'd0);
    check("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // flush with a full buffer and four words still queued
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) load(42'(64'h100 + i), 1'b0);
    p = pop_cnt;
    tick(4);
    check("t3_pops_fill", 64'(pop_cnt - p), 64'd2);
    check("t3_out_valid_full", 64'(bus.out_valid), 64'd1);
`ifdef QUEUE_READER_CNT_EN
    check("t3_cnt_before", 64'(xfer_count), 64'd8);
`endif
    en = 1'b0;
    flush = 1'b1;
    p = pop_cnt;
    tick(1);
    flush = 1'b0;
    bus.out_ready = 1'b1;
    check("t3_out_valid_flush", 64'(bus.out_valid), 64'd0);
    check("t3_q_ren_flush", 64'(bus.q_ren), 64'd1);
    tick(6);
    check("t3_pops_flush", 64'(pop_cnt - p), 64'd4);
    check("t3_q_drained", 64'(wr_ptr - rd_ptr), 64'd0);
    check("t3_busy_idle", 64'(busy), 64'd0);
`ifdef QUEUE_READER_CNT_EN
    check("t3_cnt_after", 64'(xfer_count), 64'd8);
`endif

    // en dropped with a full buffer
    bus.out_ready = 1'b0;
    load(42'h2A0, 1'b1);
    load(42'h2A1, 1'b1);
    load(42'h2A2, 1'b0);
    load(42'h2A3, 1'b0);
    en = 1'b1;
    p = pop_cnt;
    tick(4);
    en = 1'b0;
    tick(3);
    check("t4_pops", 64'(pop_cnt - p), 64'd2);
    bus.out_ready = 1'b1;
    tick(1);
    check("t4_busy_one_left", 64'(busy), 64'd1);
    tick(1);
    check("t4_busy_done", 64'(busy), 64'd0);
    check("t4_sb_empty", 64'(exp_q.size()), 64'd0);
    tick(2);
    check("t4_no_more_pops", 64'(pop_cnt - p), 64'd2);

    // asynchronous reset with one word buffered
    bus.out_ready = 1'b0;
    en = 1'b1;
    tick(2);
    check("t5_out_valid_pre", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_out_valid_rst", 64'(bus.out_valid), 64'd0);
    check("t5_busy_rst", 64'(busy), 64'd0);
    check("t5_q_ren_rst", 64'(bus.q_ren), 64'd0);
`ifdef QUEUE_READER_CNT_EN
    check("t5_cnt_rst", 64'(xfer_count), 64'd0);
`endif
    en = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("t5_busy_post", 64'(busy), 64'd0);
    check("t5_out_valid_post", 64'(bus.out_valid), 64'd0);

    // drain the leftover upstream word from IDLE via flush
    bus.out_ready = 1'b1;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(3);
    check("t6_q_drained", 64'(wr_ptr - rd_ptr), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);

`ifdef QUEUE_READER_CNT_EN
    // counter wrap: 65537 transfers leave the count at 1
    for (int i = 0; i < 65537; i++) load(42'(i), 1'b1);
    en = 1'b1;
    tick(65537 + 4);
    en = 1'b0;
    check("t7_cnt_wrap", 64'(xfer_count), 64'd1);
    check("t7_sb_empty", 64'(exp_q.size()), 64'd0);
`endif

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
